word_assemble: RTL and testbench

Assembles a stream of narrow input slices into one wide output word, the inverse of a bit-slice extractor. It sits after a narrow datapath, or a serialising link, that carries a wide word as NUM_SLICES consecutive pieces. Input and output use valid/ready handshakes. An optional sync marker realigns the slice counter and flags any partial word it throws away.

---
 rtl/word_assemble.sv | 89 ++++++++
 tb/tb_word_assemble.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/word_assemble.sv
// word_assemble: collects NUM_SLICES narrow slices into one wide word.
// The slice counter can be realigned by a sync marker on the input. A partial
// word that the marker throws away is flagged with a one-cycle sync_err.
// The assembled word sits in an output register under a valid/ready handshake.
module word_assemble #(
    parameter string ARCHITECTURE       = "BEHAVIORAL",
    parameter int    INPUT_DATA_WIDTH   = 8,
    parameter int    NUM_SLICES         = 4,
    parameter int    FIRST_SLICE_AT_MSB = 1,
    parameter int    OUTPUT_DATA_WIDTH  = INPUT_DATA_WIDTH * NUM_SLICES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUT_DATA_WIDTH-1:0]  data_in,
    input  logic                         data_in_valid,
    input  logic                         data_in_sync,
    output logic                         data_in_ready,
    output logic [OUTPUT_DATA_WIDTH-1:0] data_out,
    output logic                         data_out_valid,
    input  logic                         data_out_ready,
    output logic                         sync_err
);

    // Counter width is held at one bit or more so that NUM_SLICES=1 still has a legal vector.
    localparam int CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SLICES - 1);

    // Overwrites slice position k of word with slice and leaves every other bit unchanged.
    function automatic logic [OUTPUT_DATA_WIDTH-1:0] place_slice(
        input logic [OUTPUT_DATA_WIDTH-1:0] word,
        input logic [INPUT_DATA_WIDTH-1:0]  slice,
        input logic [CNT_W-1:0]             k
    );
        logic [OUTPUT_DATA_WIDTH-1:0] mask;
        logic [OUTPUT_DATA_WIDTH-1:0] ext;
        int                           lsb;
        if (FIRST_SLICE_AT_MSB != 0)
            lsb = OUTPUT_DATA_WIDTH - (int'(k) + 1) * INPUT_DATA_WIDTH;
        else
            lsb = int'(k) * INPUT_DATA_WIDTH;
        mask = OUTPUT_DATA_WIDTH'({INPUT_DATA_WIDTH{1'b1}}) << lsb;
        ext  = OUTPUT_DATA_WIDTH'(slice) << lsb;
        return (word & ~mask) | ext;
    endfunction

    if (ARCHITECTURE == "BEHAVIORAL") begin : g_behavioral
        logic [CNT_W-1:0]             cnt;
        logic [OUTPUT_DATA_WIDTH-1:0] acc;
        logic [CNT_W-1:0]             k;
        logic                         last;
        logic                         accept;

        // Only a completing slice can stall, and only when the held word is not leaving this cycle.
        assign data_in_ready = (cnt != LAST_IDX) | ~data_out_valid | data_out_ready;

        // A sync slice is always slice 0. Its effective index decides both its placement and whether it completes a word.
        always_comb begin
            k      = data_in_sync ? '0 : cnt;
            last   = (k == LAST_IDX);
            accept = data_in_valid & data_in_ready;
        end

        // Accumulate slices, move the completed word to the output register, and flag discarded partial words.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt            <= '0;
                acc            <= '0;
                data_out       <= '0;
                data_out_valid <= 1'b0;
                sync_err       <= 1'b0;
            end else begin
                sync_err <= accept & data_in_sync & (cnt != '0);
                if (accept) begin
                    if (last) begin
                        data_out <= place_slice(acc, data_in, k);
                        cnt      <= '0;
                    end else begin
                        acc <= place_slice(acc, data_in, k);
                        cnt <= k + CNT_W'(1);
                    end
                end
                data_out_valid <= (accept & last) | (data_out_valid & ~data_out_ready);
            end
        end
    end else if (ARCHITECTURE == "VIRTEX5") begin : g_virtex5
    end else if (ARCHITECTURE == "VIRTEX6") begin : g_virtex6
    end

endmodule

// File: tb/tb_word_assemble.sv
// tb_word_assemble: drives two instances, one with MSB-first placement and one with
// LSB-first placement, from the same stimulus. The stimulus process runs a slice-list
// model and queues the expected words. A separate monitor checks each word when it
// leaves the DUT.
module tb_word_assemble;
    localparam int IW = 8;
    localparam int N  = 4;
    localparam int OW = IW * N;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] din;
    logic          din_v;
    logic          din_s;
    logic          dor;
    logic [OW-1:0] dout_m, dout_l;
    logic          rdy_m, rdy_l, dov_m, dov_l, se_m, se_l;

    always #5 clk = ~clk;

    word_assemble #(.INPUT_DATA_WIDTH(IW), .NUM_SLICES(N), .FIRST_SLICE_AT_MSB(1)) u_msb (
        .clk(clk), .rst(rst), .data_in(din), .data_in_valid(din_v), .data_in_sync(din_s),
        .data_in_ready(rdy_m), .data_out(dout_m), .data_out_valid(dov_m),
        .data_out_ready(dor), .sync_err(se_m));

    word_assemble #(.INPUT_DATA_WIDTH(IW), .NUM_SLICES(N), .FIRST_SLICE_AT_MSB(0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(din), .data_in_valid(din_v), .data_in_sync(din_s),
        .data_in_ready(rdy_l), .data_out(dout_l), .data_out_valid(dov_l),
        .data_out_ready(dor), .sync_err(se_l));

    int            tests = 0;
    int            fails = 0;
    logic [IW-1:0] cur[$];
    logic [OW-1:0] expq_m[$];
    logic [OW-1:0] expq_l[$];
    bit            held   = 1'b0;
    bit            exp_se = 1'b0;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: apply the inputs, check ready against the model, then advance the model at the edge.
    task automatic cycle(input bit r, input bit v, input logic [IW-1:0] d, input bit s, input bit ordy);
        bit            exp_rdy;
        bit            acc;
        bit            done;
        logic [OW-1:0] wm, wl;
        rst = r; din_v = v; din = d; din_s = s; dor = ordy;
        #1;
        exp_rdy = (cur.size() != N - 1) || !held || ordy;
        if (!r) begin
            chk("ready_msb", OW'(rdy_m), OW'(exp_rdy));
            chk("ready_lsb", OW'(rdy_l), OW'(exp_rdy));
        end
        @(posedge clk);
        if (r) begin
            cur.delete(); expq_m.delete(); expq_l.delete();
            held = 1'b0; exp_se = 1'b0;
        end else begin
            acc    = v && exp_rdy;
            exp_se = acc && s && (cur.size() != 0);
            if (acc && s) cur.delete();
            if (acc) cur.push_back(d);
            done = acc && (cur.size() == N);
            if (done) begin
                wm = '0; wl = '0;
                for (int i = 0; i < N; i++) begin
                    wm = (wm << IW) | OW'(cur[i]);
                    wl = wl | (OW'(cur[i]) << (IW * i));
                end
                expq_m.push_back(wm);
                expq_l.push_back(wl);
                cur.delete();
            end
            held = done || (held && !ordy);
        end
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dout_msb"}, dout_m, '0);
        chk({tag, "_dout_lsb"}, dout_l, '0);
        chk({tag, "_dov"}, OW'(dov_m | dov_l), '0);
        chk({tag, "_serr"}, OW'(se_m | se_l), '0);
    endtask

    // Monitor: compares each word against the front of the expected queue, plus the valid and sync_err flags.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("out_valid_msb", OW'(dov_m), OW'(held));
            chk("out_valid_lsb", OW'(dov_l), OW'(held));
            chk("sync_err_msb", OW'(se_m), OW'(exp_se));
            chk("sync_err_lsb", OW'(se_l), OW'(exp_se));
            if (dov_m) begin
                if (expq_m.size() == 0) begin
                    chk("unexpected_word", dout_m, 'x);
                end else begin
                    chk("word_msb", dout_m, expq_m[0]);
                    chk("word_lsb", dout_l, expq_l[0]);
                    if (dor) begin
                        void'(expq_m.pop_front());
                        void'(expq_l.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [IW-1:0] seq[$];
        rst = 1'b1; din = '0; din_v = 1'b0; din_s = 1'b0; dor = 1'b0;
        @(posedge clk); #1;
        cycle(1, 0, 0, 0, 0);
        chk_zero("reset");

        // Basic word, downstream always ready.
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (seq[i]) cycle(0, 1, seq[i], 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Output held: 0x05..0x07 keep accumulating, 0x08 stalls until one consume cycle.
        for (int i = 1; i <= 7; i++) cycle(0, 1, IW'(i), 0, 0);
        cycle(0, 1, 8'h08, 0, 0);
        cycle(0, 1, 8'h08, 0, 1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);

        // Sync realignment discards 0xAA,0xBB.
        seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        foreach (seq[i]) cycle(0, 1, seq[i], (seq[i] == 8'hCC), 1);
        cycle(0, 0, 0, 0, 1);

        // Continuous stream of 12 slices.
        for (int i = 0; i < 12; i++) cycle(0, 1, IW'(8'h30 + i), 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Reset mid-word, then reset with a held word.
        cycle(0, 1, 8'h11, 0, 1);
        cycle(0, 1, 8'h22, 0, 1);
        cycle(1, 1, 8'h33, 0, 1);
        chk_zero("rst_mid");
        seq = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        foreach (seq[i]) cycle(0, 1, seq[i], 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk_zero("rst_held");
        seq = '{8'h55, 8'h66, 8'h77, 8'h88};
        foreach (seq[i]) cycle(0, 1, seq[i], 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Randomized traffic with back-pressure, sync markers and occasional reset.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom % 300) == 0, ($urandom % 4) != 0, IW'($urandom),
                  ($urandom % 10) == 0, ($urandom % 3) != 0);

        // Drain and confirm that every expected word has left the DUT.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
        chk("drained", OW'(expq_m.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
